mag_window_stats: RTL

MAG_WINDOW_STATS -- requirements
Module: mag_window_stats

---
 rtl/mag_window_stats.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/mag_window_stats.sv
// mag_window_stats
//   Windowed statistics over 8-bit magnitude samples: moving average over
//   2^WIN_LOG2 samples, running peak/floor since the last clear, and a
//   hysteretic alarm with a saturating alarm-entry counter.
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   ena        global enable; low freezes all state and outputs
//   mag_in     unsigned magnitude sample
//   mag_valid  mag_in valid this cycle
//   clr        synchronous clear of all statistics (wins over mag_valid)
//   sel        stat select: 0 avg, 1 max, 2 min, 3 alarm-entry count
//   stat_out   registered selected statistic
//   alarm      registered alarm state (1 = ALERT)
//   win_full   window holds 2^WIN_LOG2 valid samples
module mag_window_stats #(
  parameter int         WIN_LOG2 = 3,
  parameter logic [7:0] TH_HI    = 8'd200,
  parameter logic [7:0] TH_LO    = 8'd150
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] mag_in,
  input  logic       mag_valid,
  input  logic       clr,
  input  logic [1:0] sel,
  output logic [7:0] stat_out,
  output logic       alarm,
  output logic       win_full
);

  localparam int DEPTH = 1 << WIN_LOG2;
  localparam int SUM_W = 8 + WIN_LOG2;
  localparam int CNT_W = WIN_LOG2 + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  typedef enum logic {QUIET = 1'b0, ALERT = 1'b1} state_t;

  logic [7:0]          buf_r [DEPTH];
  logic [WIN_LOG2-1:0] wr_ptr_r;
  logic [CNT_W-1:0]    count_r;
  logic [SUM_W-1:0]    sum_r;
  logic [SUM_W-1:0]    sum_nxt_s;
  logic [7:0]          max_r;
  logic [7:0]          min_r;
  logic [7:0]          avg_s;
  logic [7:0]          avg_r;
  logic [7:0]          entry_cnt_r;
  logic [7:0]          stat_s;
  logic                accept_s;
  logic                entry_s;
  state_t              state_r;
  state_t              state_nxt_s;

  assign accept_s = ena & mag_valid & ~clr;
  assign win_full = (count_r == CNT_FULL);
  assign alarm    = (state_r == ALERT);

  // Next running sum: add the new sample, drop the one being overwritten once full.
  always_comb begin
    sum_nxt_s = sum_r + SUM_W'(mag_in);
    if (win_full) begin
      sum_nxt_s = sum_nxt_s - SUM_W'(buf_r[wr_ptr_r]);
    end else begin
      sum_nxt_s = sum_nxt_s;
    end
  end

  // Average is only meaningful once the window is full.
  always_comb begin
    if (win_full) begin
      avg_s = sum_r[WIN_LOG2 +: 8];
    end else begin
      avg_s = 8'd0;
    end
  end

  // Output statistic select.
  always_comb begin
    case (sel)
      2'd0:    stat_s = avg_s;
      2'd1:    stat_s = max_r;
      2'd2:    stat_s = min_r;
      2'd3:    stat_s = entry_cnt_r;
      default: stat_s = 8'd0;
    endcase
  end

  // Alarm next-state: judged on the average registered one cycle earlier.
  always_comb begin
    state_nxt_s = state_r;
    entry_s     = 1'b0;
    case (state_r)
      QUIET: begin
        if (avg_r > TH_HI) begin
          state_nxt_s = ALERT;
          entry_s     = 1'b1;
        end else begin
          state_nxt_s = QUIET;
        end
      end
      ALERT: begin
        if (avg_r < TH_LO) begin
          state_nxt_s = QUIET;
        end else begin
          state_nxt_s = ALERT;
        end
      end
      default: state_nxt_s = QUIET;
    endcase
  end

  // Circular sample buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) buf_r[i] <= 8'd0;
    end else if (ena && clr) begin
      for (int i = 0; i < DEPTH; i++) buf_r[i] <= 8'd0;
    end else if (accept_s) begin
      buf_r[wr_ptr_r] <= mag_in;
    end
  end

  // Window bookkeeping, peak/floor tracking and the registered average.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      count_r  <= '0;
      sum_r    <= '0;
      max_r    <= 8'd0;
      min_r    <= 8'd255;
      avg_r    <= 8'd0;
    end else if (ena) begin
      if (clr) begin
        wr_ptr_r <= '0;
        count_r  <= '0;
        sum_r    <= '0;
        max_r    <= 8'd0;
        min_r    <= 8'd255;
        avg_r    <= 8'd0;
      end else begin
        avg_r <= avg_s;
        if (mag_valid) begin
          wr_ptr_r <= wr_ptr_r + 1'b1;
          sum_r    <= sum_nxt_s;
          if (!win_full) count_r <= count_r + 1'b1;
          if (mag_in > max_r) max_r <= mag_in;
          if (mag_in < min_r) min_r <= mag_in;
        end
      end
    end
  end

  // Alarm state, saturating entry counter and registered statistic output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= QUIET;
      entry_cnt_r <= 8'd0;
      stat_out    <= 8'd0;
    end else if (ena) begin
      if (clr) begin
        state_r     <= QUIET;
        entry_cnt_r <= 8'd0;
        stat_out    <= 8'd0;
      end else begin
        state_r  <= state_nxt_s;
        stat_out <= stat_s;
        if (entry_s && (entry_cnt_r != 8'd255)) entry_cnt_r <= entry_cnt_r + 8'd1;
      end
    end
  end

endmodule
